// File: rtl/banked_data_memory_if.sv
// Bus bundle for banked_data_memory: CPU load/store port plus the mirrored GPIO write stream.
interface banked_data_memory_if #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned FIFO_DEPTH = 8
);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wd;
  logic [31:0]       rd;
  logic              addr_err;
  logic              gpio_valid;
  logic              gpio_ready;
  logic [ADDR_W-1:0] gpio_addr;
  logic [7:0]        gpio_data;
  logic [LVL_W-1:0]  gpio_level;
  logic [15:0]       gpio_drop_cnt;
  logic              gpio_ovf;

  modport master (
    output we, addr, wd, gpio_ready,
    input  rd, addr_err, gpio_valid, gpio_addr, gpio_data, gpio_level, gpio_drop_cnt, gpio_ovf
  );

  modport slave (
    input  we, addr, wd, gpio_ready,
    output rd, addr_err, gpio_valid, gpio_addr, gpio_data, gpio_level, gpio_drop_cnt, gpio_ovf
  );
endinterface

// File: rtl/banked_data_memory.sv
// Banked byte region + word region data memory with a non-blocking GPIO mirror FIFO.
// Optional macro DMEM_READ_REG_EN registers rd/addr_err (write-first); otherwise reads are combinational.
module banked_data_memory #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned BANK_DEPTH  = 10000,
  parameter int unsigned BYTE_DEPTH  = 152100,
  parameter int unsigned WORD_DEPTH  = 1536,
  parameter int unsigned GPIO_OFFSET = 152100,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input logic                   clk,
  input logic                   rst,
  banked_data_memory_if.slave   bus
);

  localparam int unsigned NUM_BANKS = (BYTE_DEPTH + BANK_DEPTH - 1) / BANK_DEPTH;
  localparam int unsigned BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned OFF_W     = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
  localparam int unsigned WIDX_W    = (WORD_DEPTH > 1) ? $clog2(WORD_DEPTH) : 1;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W     = PTR_W + 1;

  localparam logic [ADDR_W-1:0] BYTE_END   = ADDR_W'(BYTE_DEPTH);
  localparam logic [ADDR_W-1:0] WORD_END   = ADDR_W'(BYTE_DEPTH + WORD_DEPTH);
  localparam logic [ADDR_W-1:0] GPIO_OFF_A = ADDR_W'(GPIO_OFFSET);

  logic [7:0]        byte_mem [NUM_BANKS][BANK_DEPTH];
  logic [31:0]       word_mem [WORD_DEPTH];

  logic              byte_hit;
  logic              word_hit;
  logic [BANK_W-1:0] bank_idx;
  logic [ADDR_W-1:0] bank_base;
  logic [OFF_W-1:0]  off_idx;
  logic [WIDX_W-1:0] widx;
  logic [31:0]       rd_c;
  logic              err_c;

  // Bank select by comparing against constant bank boundaries (no divider)
  always_comb begin
    bank_idx  = '0;
    bank_base = '0;
    for (int unsigned b = 1; b < NUM_BANKS; b++) begin
      if (bus.addr >= ADDR_W'(b * BANK_DEPTH)) begin
        bank_idx  = BANK_W'(b);
        bank_base = ADDR_W'(b * BANK_DEPTH);
      end
    end
  end

  assign byte_hit = (bus.addr < BYTE_END);
  assign word_hit = !byte_hit && (bus.addr < WORD_END);
  assign off_idx  = OFF_W'(bus.addr - bank_base);
  assign widx     = WIDX_W'(bus.addr - BYTE_END);
  assign err_c    = !byte_hit && !word_hit;

  // Memory arrays are intentionally not reset
  always_ff @(posedge clk) begin
    if (rst && bus.we) begin
      if (byte_hit) begin
        byte_mem[bank_idx][off_idx] <= bus.wd[7:0];
      end else if (word_hit) begin
        word_mem[widx] <= bus.wd;
      end
    end
  end

  always_comb begin
    rd_c = '0;
    if (byte_hit) begin
      rd_c = {24'b0, byte_mem[bank_idx][off_idx]};
    end else if (word_hit) begin
      rd_c = word_mem[widx];
    end
  end

`ifdef DMEM_READ_REG_EN
  logic [31:0] rd_q;
  logic        err_q;

  // Registered read; a write to the sampled address forwards the new data
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= err_c;
      if (bus.we && byte_hit) begin
        rd_q <= {24'b0, bus.wd[7:0]};
      end else if (bus.we && word_hit) begin
        rd_q <= bus.wd;
      end else begin
        rd_q <= rd_c;
      end
    end
  end

  assign bus.rd       = rd_q;
  assign bus.addr_err = err_q;
`else
  assign bus.rd       = rd_c;
  assign bus.addr_err = err_c;
`endif

  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [7:0]        fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level;
  logic [15:0]       drop_cnt;
  logic              ovf;
  logic              push_req;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;

  assign push_req = rst && bus.we && byte_hit;
  assign full     = (level == LVL_W'(FIFO_DEPTH));
  assign pop      = (level != '0) && bus.gpio_ready;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.addr + GPIO_OFF_A;
      fifo_data[wr_ptr] <= bus.wd[7:0];
    end
  end

  // Pointer/level/overflow bookkeeping; a full FIFO drops rather than stalls
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      drop_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (drop) begin
        ovf <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  assign bus.gpio_valid    = (level != '0);
  assign bus.gpio_addr     = bus.gpio_valid ? fifo_addr[rd_ptr] : '0;
  assign bus.gpio_data     = bus.gpio_valid ? fifo_data[rd_ptr] : '0;
  assign bus.gpio_level    = level;
  assign bus.gpio_drop_cnt = drop_cnt;
  assign bus.gpio_ovf      = ovf;

endmodule

// File: tb/tb_banked_data_memory.sv
// Randomised self-checking bench for banked_data_memory against a queue/associative-array model.
module tb_banked_data_memory;

  localparam int unsigned BYTE_DEPTH  = 152100;
  localparam int unsigned WORD_DEPTH  = 1536;
  localparam int unsigned GPIO_OFFSET = 152100;
  localparam int unsigned FIFO_DEPTH  = 8;
  localparam int unsigned LVL_W       = $clog2(FIFO_DEPTH) + 1;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } entry_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   errors  = 0;

  logic [7:0]  byte_model [int unsigned];
  logic [31:0] word_model [int unsigned];
  entry_t      q [$];
  logic [15:0] m_drop = '0;
  logic        m_ovf  = 1'b0;

  banked_data_memory_if #(.ADDR_W(32), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  banked_data_memory dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (a < BYTE_DEPTH) return byte_model.exists(a) ? {24'b0, byte_model[a]} : 'x;
    if (a < BYTE_DEPTH + WORD_DEPTH) return word_model.exists(a - BYTE_DEPTH) ? word_model[a - BYTE_DEPTH] : 'x;
    return 32'h0;
  endfunction

  function automatic logic model_err(input logic [31:0] a);
    return a >= BYTE_DEPTH + WORD_DEPTH;
  endfunction

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d, input logic r);
    bus.we = w; bus.addr = a; bus.wd = d; bus.gpio_ready = r;
  endtask

  // Advance one clock and apply the same edge to the model
  task automatic tick();
    bit do_pop;
    bit is_byte;
    int sz;
    @(posedge clk);
    if (!rst) begin
      q.delete();
      m_drop = '0;
      m_ovf  = 1'b0;
    end else begin
      sz      = q.size();
      do_pop  = (sz != 0) && bus.gpio_ready;
      is_byte = bus.we && (bus.addr < BYTE_DEPTH);
      if (bus.we) begin
        if (bus.addr < BYTE_DEPTH) byte_model[bus.addr] = bus.wd[7:0];
        else if (bus.addr < BYTE_DEPTH + WORD_DEPTH) word_model[bus.addr - BYTE_DEPTH] = bus.wd;
      end
      if (do_pop) void'(q.pop_front());
      if (is_byte) begin
        if (sz < FIFO_DEPTH || do_pop) q.push_back('{a: bus.addr + GPIO_OFFSET, d: bus.wd[7:0]});
        else begin
          if (m_drop != 16'hFFFF) m_drop++;
          m_ovf = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    tick(); tick();
    vectors++; if (bus.gpio_level !== LVL_W'(0)) begin errors++; $display("FAIL reset_level got %0d exp 0", bus.gpio_level); end
    vectors++; if (bus.gpio_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.gpio_valid); end
    vectors++; if (bus.gpio_drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d exp 0", bus.gpio_drop_cnt); end
    vectors++; if (bus.gpio_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", bus.gpio_ovf); end
    vectors++; if (bus.gpio_addr !== 32'd0 || bus.gpio_data !== 8'd0) begin errors++; $display("FAIL reset_head got %h/%h exp 0/0", bus.gpio_addr, bus.gpio_data); end
    rst = 1'b1;
  endtask

  task automatic test_basic_rw();
    logic [31:0] addrs [3];
    logic [31:0] exps  [3];
    addrs = '{32'd5, 32'd10000, 32'd152100};
    exps  = '{32'h000000AB, 32'h00000011, 32'hDEADBEEF};
    drive(1'b1, 32'd5,      32'hFFFFFFAB, 1'b1); tick();
    drive(1'b1, 32'd10000,  32'h12345611, 1'b1); tick();
    drive(1'b1, 32'd152100, 32'hDEADBEEF, 1'b1); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, addrs[i], 32'd0, 1'b1);
`ifndef DMEM_READ_REG_EN
      #1;
      vectors++; if (bus.rd !== exps[i]) begin errors++; $display("FAIL comb_rd addr=%0d got %h exp %h", addrs[i], bus.rd, exps[i]); end
`endif
      tick();
      vectors++; if (bus.rd !== exps[i]) begin errors++; $display("FAIL basic_rd addr=%0d got %h exp %h", addrs[i], bus.rd, exps[i]); end
      vectors++; if (bus.addr_err !== 1'b0) begin errors++; $display("FAIL basic_err addr=%0d got %b exp 0", addrs[i], bus.addr_err); end
    end
  endtask

  task automatic test_unmapped();
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    repeat (FIFO_DEPTH + 2) tick();
    drive(1'b0, 32'd153636, 32'd0, 1'b0); tick();
    vectors++; if (bus.rd !== 32'd0 || bus.addr_err !== 1'b1) begin errors++; $display("FAIL unmapped_rd got %h/%b exp 0/1", bus.rd, bus.addr_err); end
    drive(1'b1, 32'd153636, 32'h55, 1'b0); tick();
    vectors++; if (bus.rd !== 32'd0 || bus.addr_err !== 1'b1) begin errors++; $display("FAIL unmapped_wr got %h/%b exp 0/1", bus.rd, bus.addr_err); end
    vectors++; if (bus.gpio_level !== LVL_W'(0)) begin errors++; $display("FAIL unmapped_level got %0d exp 0", bus.gpio_level); end
    drive(1'b0, 32'hFFFFFFFF, 32'd0, 1'b0); tick();
    vectors++; if (bus.rd !== 32'd0 || bus.addr_err !== 1'b1) begin errors++; $display("FAIL unmapped_top got %h/%b exp 0/1", bus.rd, bus.addr_err); end
    drive(1'b0, 32'd5, 32'd0, 1'b0); tick();
    vectors++; if (bus.rd !== 32'h000000AB) begin errors++; $display("FAIL unmapped_keep5 got %h exp 000000ab", bus.rd); end
    drive(1'b0, 32'd152100, 32'd0, 1'b0); tick();
    vectors++; if (bus.rd !== 32'hDEADBEEF) begin errors++; $display("FAIL unmapped_keepw got %h exp deadbeef", bus.rd); end
    drive(1'b1, 32'd153635, 32'h12345678, 1'b0); tick();
    vectors++; if (bus.rd !== 32'h12345678 || bus.addr_err !== 1'b0) begin errors++; $display("FAIL last_word got %h/%b exp 12345678/0", bus.rd, bus.addr_err); end
  endtask

  task automatic test_gpio_single();
    drive(1'b1, 32'd3, 32'h0000007E, 1'b0); tick();
    drive(1'b0, 32'd3, 32'd0, 1'b0);
    vectors++; if (bus.gpio_valid !== 1'b1 || bus.gpio_addr !== 32'd152103 || bus.gpio_data !== 8'h7E) begin
      errors++; $display("FAIL gpio_head got v=%b a=%0d d=%h exp 1/152103/7e", bus.gpio_valid, bus.gpio_addr, bus.gpio_data); end
    tick();
    vectors++; if (bus.gpio_valid !== 1'b1 || bus.gpio_addr !== 32'd152103 || bus.gpio_data !== 8'h7E) begin
      errors++; $display("FAIL gpio_hold got v=%b a=%0d d=%h exp 1/152103/7e", bus.gpio_valid, bus.gpio_addr, bus.gpio_data); end
    vectors++; if (bus.rd !== 32'h7E) begin errors++; $display("FAIL gpio_rd3 got %h exp 7e", bus.rd); end
    drive(1'b0, 32'd3, 32'd0, 1'b1); tick();
    vectors++; if (bus.gpio_valid !== 1'b0 || bus.gpio_level !== LVL_W'(0)) begin
      errors++; $display("FAIL gpio_pop got v=%b l=%0d exp 0/0", bus.gpio_valid, bus.gpio_level); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, $urandom_range(0, BYTE_DEPTH - 1), $urandom, 1'b0); tick();
    end
    vectors++; if (bus.gpio_level !== LVL_W'(8) || bus.gpio_drop_cnt !== 16'd2 || bus.gpio_ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_fill got l=%0d drop=%0d ovf=%b exp 8/2/1", bus.gpio_level, bus.gpio_drop_cnt, bus.gpio_ovf); end
    drive(1'b1, $urandom_range(0, BYTE_DEPTH - 1), $urandom, 1'b1); tick();
    vectors++; if (bus.gpio_level !== LVL_W'(8) || bus.gpio_drop_cnt !== 16'd2) begin
      errors++; $display("FAIL ovf_pushpop got l=%0d drop=%0d exp 8/2", bus.gpio_level, bus.gpio_drop_cnt); end
    drive(1'b1, 32'd152200, $urandom, 1'b0); tick();
    vectors++; if (bus.gpio_level !== LVL_W'(8) || bus.gpio_drop_cnt !== 16'd2) begin
      errors++; $display("FAIL word_nomirror got l=%0d drop=%0d exp 8/2", bus.gpio_level, bus.gpio_drop_cnt); end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      drive(1'b0, 32'd0, 32'd0, 1'b1);
      vectors++; if (bus.gpio_valid !== 1'b1 || bus.gpio_addr !== q[0].a || bus.gpio_data !== q[0].d) begin
        errors++; $display("FAIL drain_head[%0d] got %0d/%h exp %0d/%h", i, bus.gpio_addr, bus.gpio_data, q[0].a, q[0].d); end
      tick();
    end
    vectors++; if (bus.gpio_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got v=%b exp 0", bus.gpio_valid); end
  endtask

  task automatic test_random();
    int unsigned pool [12];
    logic [31:0] a;
    pool = '{0, 1, 5, 9999, 10000, 10001, 149999, 150000, 152099, 152100, 152101, 153635};
    foreach (pool[i]) begin
      drive(1'b1, pool[i], $urandom, 1'($urandom)); tick();
    end
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 7) a = pool[$urandom_range(0, 11)];
      else a = $urandom_range(153636, 32'hFFFFFFFF);
      drive(1'($urandom), a, $urandom, 1'($urandom)); tick();
      vectors++; if (bus.rd !== model_rd(a) || bus.addr_err !== model_err(a)) begin
        errors++; $display("FAIL rand_rd[%0d] addr=%0d got %h/%b exp %h/%b", n, a, bus.rd, bus.addr_err, model_rd(a), model_err(a)); end
      vectors++; if (bus.gpio_level !== LVL_W'(q.size()) || bus.gpio_valid !== (q.size() != 0) ||
                     bus.gpio_drop_cnt !== m_drop || bus.gpio_ovf !== m_ovf) begin
        errors++; $display("FAIL rand_fifo[%0d] got l=%0d v=%b drop=%0d ovf=%b exp l=%0d drop=%0d ovf=%b",
                           n, bus.gpio_level, bus.gpio_valid, bus.gpio_drop_cnt, bus.gpio_ovf, q.size(), m_drop, m_ovf); end
      if (q.size() != 0) begin
        vectors++; if (bus.gpio_addr !== q[0].a || bus.gpio_data !== q[0].d) begin
          errors++; $display("FAIL rand_head[%0d] got %0d/%h exp %0d/%h", n, bus.gpio_addr, bus.gpio_data, q[0].a, q[0].d); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp5;
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    repeat (FIFO_DEPTH + 2) tick();
    drive(1'b1, 32'd152100, 32'hDEADBEEF, 1'b0); tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, $urandom_range(100, BYTE_DEPTH - 1), $urandom, 1'b0); tick();
    end
    vectors++; if (bus.gpio_level !== LVL_W'(5)) begin errors++; $display("FAIL mid_fill got %0d exp 5", bus.gpio_level); end
    exp5 = model_rd(32'd5);
    rst = 1'b0;
    drive(1'b1, 32'd5, 32'h99, 1'b1); tick();
    rst = 1'b1;
    drive(1'b0, 32'd5, 32'd0, 1'b0);
    vectors++; if (bus.gpio_level !== LVL_W'(0) || bus.gpio_valid !== 1'b0 || bus.gpio_drop_cnt !== 16'd0 || bus.gpio_ovf !== 1'b0) begin
      errors++; $display("FAIL mid_reset got l=%0d v=%b drop=%0d ovf=%b exp 0/0/0/0", bus.gpio_level, bus.gpio_valid, bus.gpio_drop_cnt, bus.gpio_ovf); end
    tick();
    vectors++; if (bus.rd !== exp5) begin errors++; $display("FAIL mid_we_ignored got %h exp %h", bus.rd, exp5); end
    drive(1'b0, 32'd152100, 32'd0, 1'b0); tick();
    vectors++; if (bus.rd !== 32'hDEADBEEF) begin errors++; $display("FAIL mid_word got %h exp deadbeef", bus.rd); end
  endtask

  initial begin
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    test_reset();
    test_basic_rw();
    test_unmapped();
    test_gpio_single();
    test_overflow();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
